// File: rtl/regfile_wb.sv
// Writeback register file: 32 x DW registers, two combinational read ports with
// write-through bypass, and a valid/ready dump engine that streams every register out.
module regfile_wb #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    input  logic          dump_start,
    input  logic          dump_ready,
    output logic          dump_valid,
    output logic [AW-1:0] dump_idx,
    output logic [DW-1:0] dump_data,
    output logic          dump_busy
);

    localparam int            NREG     = 1 << AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } dump_state_t;

    logic [DW-1:0] r_regs [NREG];
    dump_state_t   r_state;
    logic [AW-1:0] r_idx;
    logic          r_valid;
    logic          r_busy;

    logic          w_wr_en;
    logic          w_hit1;
    logic          w_hit2;
    logic          w_hit_dump;

    assign w_wr_en    = we && (waddr != '0);
    assign w_hit1     = we && (waddr == raddr1);
    assign w_hit2     = we && (waddr == raddr2);
    assign w_hit_dump = we && (waddr == r_idx);

    // NOTE: the whole array is reset because software relies on every register reading
    // zero after reset; a RAM macro could not honour that, so this stays in flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Register 0 reads zero before bypass, so a write to r0 never shows up anywhere.
    assign rdata1    = (raddr1 == '0) ? '0 : (w_hit1     ? wdata : r_regs[raddr1]);
    assign rdata2    = (raddr2 == '0) ? '0 : (w_hit2     ? wdata : r_regs[raddr2]);
    assign dump_data = (r_idx  == '0) ? '0 : (w_hit_dump ? wdata : r_regs[r_idx]);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge values and the order of statements below does not matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dump_start) begin
                        r_state <= S_RUN;
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_valid && dump_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_IDLE;
                            r_idx   <= '0;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx <= r_idx + AW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dump_valid = r_valid;
    assign dump_busy  = r_busy;
    assign dump_idx   = r_idx;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios followed by randomized traffic,
// all compared against a behavioural array-and-counter model of the register file.
module tb_regfile_wb;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr1;
    logic [DW-1:0] rdata1;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata2;
    logic          dump_start;
    logic          dump_ready;
    logic          dump_valid;
    logic [AW-1:0] dump_idx;
    logic [DW-1:0] dump_data;
    logic          dump_busy;

    regfile_wb #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: plain array of register contents plus "dump in progress / next index".
    logic [DW-1:0] m_regs [32];
    bit            m_busy;
    int            m_idx;

    int            beat_idx_q [$];
    logic [DW-1:0] beat_data_q [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input int a);
        if (a == 0) return '0;
        if (we && int'(waddr) == a) return wdata;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = 1'b0;
        m_idx  = 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        if (m_busy && dump_ready) begin
            if (m_idx == 31) begin
                m_busy = 1'b0;
                m_idx  = 0;
            end else begin
                m_idx++;
            end
        end else if (!m_busy && dump_start) begin
            m_busy = 1'b1;
            m_idx  = 0;
        end
        if (we && waddr != 0) m_regs[waddr] = wdata;
    endtask

    task automatic check_outputs();
        check("rdata1", rdata1, exp_read(int'(raddr1)));
        check("rdata2", rdata2, exp_read(int'(raddr2)));
        check("dump_valid", 32'(dump_valid), 32'(m_busy));
        check("dump_busy", 32'(dump_busy), 32'(m_busy));
        check("dump_idx", 32'(dump_idx), 32'(m_idx));
        if (m_busy) check("dump_data", dump_data, exp_read(m_idx));
        if (dump_valid && dump_ready) begin
            beat_idx_q.push_back(int'(dump_idx));
            beat_data_q.push_back(dump_data);
        end
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Asserts reset in the middle of the low phase, away from any rising edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_dump_valid", 32'(dump_valid), 32'd0);
        check("rst_dump_busy", 32'(dump_busy), 32'd0);
        check("rst_dump_idx", 32'(dump_idx), 32'd0);
        check("rst_rdata1", rdata1, exp_read(int'(raddr1)));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_idle(input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            cycle();
            n++;
        end
        check("dump_finished_in_budget", 32'(m_busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
        model_reset();
        @(negedge clk);
        raddr1 = 5'd7; raddr2 = 5'd31;
        cycle();
        check("reset_rdata1", rdata1, 32'd0);
        rst = 1'b0;
        cycle();

        // Async reset clears a freshly written register immediately.
        we = 1'b1; waddr = 5'd5; wdata = 32'h1234;
        cycle();
        we = 1'b0; raddr1 = 5'd5;
        #1 check("r5_written", rdata1, 32'h1234);
        async_reset();
        #1 check("r5_after_reset", rdata1, 32'd0);
        cycle();

        // Writes to r0 are invisible, before and after the edge.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0;
        #1 check("r0_same_cycle", rdata1, 32'd0);
        cycle();
        we = 1'b0;
        #1 check("r0_after_edge", rdata1, 32'd0);
        cycle();

        // Bypass on r31, then stored value.
        we = 1'b1; waddr = 5'd31; wdata = 32'hDEAD_BEEF; raddr2 = 5'd31;
        #1 check("ra_bypass", rdata2, 32'hDEAD_BEEF);
        cycle();
        we = 1'b0;
        #1 check("ra_stored", rdata2, 32'hDEAD_BEEF);
        cycle();

        for (int k = 1; k < 32; k++) begin
            we = 1'b1; waddr = AW'(k); wdata = 32'(k * 16);
            cycle();
        end
        we = 1'b0;

        // Full dump with dump_ready held high.
        beat_idx_q.delete(); beat_data_q.delete();
        dump_ready = 1'b1; dump_start = 1'b1;
        cycle();
        dump_start = 1'b0;
        run_to_idle(40);
        check("full_beats", 32'(beat_idx_q.size()), 32'd32);
        for (int k = 0; k < 32 && k < beat_idx_q.size(); k++) begin
            check("full_beat_idx", 32'(beat_idx_q[k]), 32'(k));
            check("full_beat_data", beat_data_q[k], 32'(k * 16));
        end
        check("full_end_valid", 32'(dump_valid), 32'd0);
        check("full_end_busy", 32'(dump_busy), 32'd0);

        // Backpressure at idx 7 with an ignored dump_start.
        beat_idx_q.delete(); beat_data_q.delete();
        dump_start = 1'b1;
        cycle();
        dump_start = 1'b0;
        for (int n = 0; n < 40 && dump_idx != 5'd7; n++) cycle();
        check("bp_reached_7", 32'(dump_idx), 32'd7);
        dump_ready = 1'b0; dump_start = 1'b1;
        repeat (3) begin
            #1;
            check("bp_hold_idx", 32'(dump_idx), 32'd7);
            check("bp_hold_data", dump_data, 32'h70);
            cycle();
        end
        dump_ready = 1'b1; dump_start = 1'b0;
        #1 check("bp_resume_idx", 32'(dump_idx), 32'd7);
        cycle();
        check("bp_next_idx", 32'(dump_idx), 32'd8);
        run_to_idle(40);
        check("bp_beats", 32'(beat_idx_q.size()), 32'd32);
        if (beat_idx_q.size() > 0) check("bp_last_idx", 32'(beat_idx_q[beat_idx_q.size()-1]), 32'd31);
        repeat (3) cycle();

        // Reset mid-dump, then restart from index 0 with all-zero contents.
        dump_start = 1'b1;
        cycle();
        dump_start = 1'b0;
        for (int n = 0; n < 40 && dump_idx != 5'd12; n++) cycle();
        check("mid_reached_12", 32'(dump_idx), 32'd12);
        async_reset();
        repeat (2) cycle();
        beat_idx_q.delete(); beat_data_q.delete();
        dump_start = 1'b1;
        cycle();
        dump_start = 1'b0;
        #1 check("restart_idx0", 32'(dump_idx), 32'd0);
        check("restart_data0", dump_data, 32'd0);
        run_to_idle(40);
        check("restart_beats", 32'(beat_idx_q.size()), 32'd32);
        foreach (beat_data_q[k]) check("restart_zero", beat_data_q[k], 32'd0);

        // Randomized concurrent traffic.
        for (int n = 0; n < 1500; n++) begin
            we         = 1'($urandom_range(0, 1));
            waddr      = AW'($urandom);
            wdata      = $urandom;
            raddr1     = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom);
            raddr2     = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom);
            if ($urandom_range(0, 3) == 0 && m_busy) waddr = AW'(m_idx);
            dump_start = ($urandom_range(0, 15) == 0);
            dump_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) async_reset();
            else cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
